drum_timing_gen: RTL and testbench
==================================

Name: drum_timing_gen

Overview:
- Generates the bit-time and word-time sequencing that the CPU datapath consumes (T0, T1, T2, T13, T21, T28, T29, TE, TF, TS).
- Locks a bit/word counter pair to the drum origin mark, which is qualified by a bit-rate enable derived from the fabric clock.
- Monitors alignment on every revolution and re-hunts after repeated misses.
- Sits beside the CPU top level and feeds its timing inputs directly.

Parameters:
- BITS_PER_WORD, 29, bit times per word; bits are numbered 1..29.
- WORDS_PER_LINE, 108, word times per drum revolution; words are numbered 0..107.
- MISS_LIMIT, 2, consecutive revolutions without an origin mark before dropping to HUNT.

Ports:
- CLOCK  in  1  system clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- BIT_EN  in  1  one-CLOCK pulse per drum bit time.
- ORIGIN  in  1  drum origin mark, sampled only with BIT_EN; the next bit is word 0, bit 1.
- STEP_MODE  in  1  maintenance single-step select (used only with the optional feature).
- STEP  in  1  one-CLOCK step pulse (used only with the optional feature).
- BIT_TIME  out  5  current bit number, 1..29; 0 while hunting.
- WORD_TIME  out  7  current word number, 0..107.
- T0, T1, T2, T13, T21, T28, T29  out  1 each  bit-time strobes.
- TE  out  1  even word time.
- TF  out  1  odd word time.
- TS  out  1  last word of the revolution (word 107).
- LOCKED  out  1  counters are aligned to the drum.
- SYNC_ERR  out  1  sticky flag: origin mark arrived at an unexpected position.

Behaviour:
- Reset: state=HUNT, BIT_TIME=0, WORD_TIME=0, miss count=0. All strobes, TE, TF, TS, LOCKED and SYNC_ERR are 0.
- "adv" means BIT_EN=1. Nothing changes on cycles where adv=0.
- HUNT:
  - Counters are held at 0/0; all strobes are 0.
  - On adv and ORIGIN: counters load bit 1, word 0; state goes to LOCKED.
- LOCKED, on adv:
  - Bit counter: 1->2->...->29->1.
  - When the bit wraps 29->1, the word counter increments; 107 wraps to 0.
- Expected origin: adv with ORIGIN while the counters are at word 107, bit 29.
  - The natural wrap then occurs and the miss count clears.
- Unexpected origin: ORIGIN at any other position.
  - SYNC_ERR is set and the counters force-load word 0, bit 1.
  - The miss count clears and the state stays LOCKED.
- Missed origin: adv at word 107, bit 29 with ORIGIN=0.
  - The counters wrap normally and the miss count increments.
  - When the count reaches MISS_LIMIT: state goes to HUNT, counters clear, and LOCKED drops on the next cycle.
- SYNC_ERR clears only on rst or on a HUNT->LOCKED transition.
- Outputs are registered and reflect the counters in the same cycle the counters update; there is no extra latency beyond the counter register.
  - Tn = LOCKED and BIT_TIME==n.
  - T0 = LOCKED and BIT_TIME==29, i.e. coincident with T29 as the word-boundary strobe.
  - TE = LOCKED and WORD_TIME[0]==0.
  - TF = LOCKED and WORD_TIME[0]==1.
  - TS = LOCKED and WORD_TIME==107.
- Simultaneous rst and adv/ORIGIN: rst wins.
- A reset in mid-revolution always returns to HUNT.

Optional Feature:
- Macro: DRUM_TIMING_STEP_EN.
- Defined:
  - While STEP_MODE=1, BIT_EN is ignored and each STEP pulse acts as one adv, including origin checking against ORIGIN sampled in that cycle.
  - Entering or leaving STEP_MODE does not alter the counters.
- Undefined: STEP_MODE and STEP are ignored and the step logic is not synthesized.

Decomposition:
- Shared package g15_timing_pkg:
  - Constants BITS_PER_WORD=29, WORDS_PER_LINE=108 and MISS_LIMIT default.
  - Typedefs bit_time_t (logic [4:0]) and word_time_t (logic [6:0]).
  - Enum timing_state_e {HUNT, LOCKED}.
- One natural sub-module, drum_bit_word_ctr: the bit/word counter pair with load and advance inputs and a wrap flag.
- The FSM, miss counter and strobe decode stay in the parent.

Test Plan:
- Lock: rst, then BIT_EN every 4 clocks, ORIGIN on the 10th adv -> next adv gives BIT_TIME=1, WORD_TIME=0, LOCKED=1, T1=1, TE=1.
- Full revolution: after lock, apply 3132 adv with ORIGIN on the 3132nd (word 107, bit 29) -> T29 and T0 pulse every 29 adv, TS high for bits 1..29 of word 107, SYNC_ERR=0, counters return to 0/1.
- Misaligned origin: after lock, ORIGIN at word 40, bit 13 -> SYNC_ERR=1 and counters reload 0/1 on that adv; LOCKED stays 1.
- Lost sync: MISS_LIMIT=2 with no ORIGIN for two revolutions -> after the second wrap, LOCKED=0, BIT_TIME=0, all strobes 0; the next ORIGIN relocks and clears SYNC_ERR.
- Mid-operation reset: rst asserted at word 55, bit 21 coincident with adv -> next cycle HUNT, all outputs 0.
- Step mode (with DRUM_TIMING_STEP_EN): locked, STEP_MODE=1, BIT_EN toggling, 3 STEP pulses -> counters advance exactly 3 bits; without the macro, the counters follow BIT_EN only.

Source files
------------

// File: rtl/g15_timing_pkg.sv
// Shared drum timing constants, counter types and lock-state encoding.
package g15_timing_pkg;

    localparam int BITS_PER_WORD      = 29;
    localparam int WORDS_PER_LINE     = 108;
    localparam int MISS_LIMIT_DEFAULT = 2;

    typedef logic [4:0] bit_time_t;
    typedef logic [6:0] word_time_t;

    typedef enum logic {
        HUNT,
        LOCKED
    } timing_state_e;

    localparam bit_time_t  FIRST_BIT = bit_time_t'(1);
    localparam bit_time_t  LAST_BIT  = bit_time_t'(BITS_PER_WORD);
    localparam word_time_t LAST_WORD = word_time_t'(WORDS_PER_LINE - 1);

endpackage

// File: rtl/drum_bit_word_ctr.sv
// Bit (1..29) / word (0..107) counter pair with clear, origin load and advance.
module drum_bit_word_ctr
    import g15_timing_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic       adv_i,
    output bit_time_t  bit_o,
    output word_time_t word_o,
    output logic       wrap_o
);

    bit_time_t  bit_q, bit_d;
    word_time_t word_q, word_d;

    // Clear beats load beats advance; a load places the counters on word 0, bit 1.
    always_comb begin
        bit_d  = bit_q;
        word_d = word_q;
        if (clr_i) begin
            bit_d  = '0;
            word_d = '0;
        end else if (load_i) begin
            bit_d  = FIRST_BIT;
            word_d = '0;
        end else if (adv_i) begin
            if (bit_q == LAST_BIT) begin
                bit_d  = FIRST_BIT;
                word_d = (word_q == LAST_WORD) ? '0 : word_q + 1'b1;
            end else begin
                bit_d = bit_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_q  <= '0;
            word_q <= '0;
        end else begin
            bit_q  <= bit_d;
            word_q <= word_d;
        end
    end

    assign bit_o  = bit_q;
    assign word_o = word_q;
    assign wrap_o = (bit_q == LAST_BIT) && (word_q == LAST_WORD);

endmodule

// File: rtl/drum_timing_gen.sv
// Drum bit/word timing generator: origin lock, miss tracking and T-strobe decode.
// Optional maintenance single-step is built in when DRUM_TIMING_STEP_EN is defined.
module drum_timing_gen #(
    parameter int MISS_LIMIT = g15_timing_pkg::MISS_LIMIT_DEFAULT
) (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       BIT_EN,
    input  logic       ORIGIN,
    input  logic       STEP_MODE,
    input  logic       STEP,
    output logic [4:0] BIT_TIME,
    output logic [6:0] WORD_TIME,
    output logic       T0,
    output logic       T1,
    output logic       T2,
    output logic       T13,
    output logic       T21,
    output logic       T28,
    output logic       T29,
    output logic       TE,
    output logic       TF,
    output logic       TS,
    output logic       LOCKED,
    output logic       SYNC_ERR
);

    import g15_timing_pkg::*;

    localparam int MISS_W = $clog2(MISS_LIMIT + 1);

    timing_state_e     state_q, state_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              sync_err_q, sync_err_d;
    logic              adv;
    logic              ctr_clr, ctr_load, ctr_adv, at_end;
    bit_time_t         bit_cur;
    word_time_t        word_cur;
    logic              locked;

`ifdef DRUM_TIMING_STEP_EN
    assign adv = STEP_MODE ? STEP : BIT_EN;
`else
    logic unused_step;
    assign unused_step = STEP_MODE ^ STEP;
    assign adv         = BIT_EN;
`endif

    drum_bit_word_ctr u_ctr (
        .clk_i  (CLOCK),
        .rst_i  (rst),
        .clr_i  (ctr_clr),
        .load_i (ctr_load),
        .adv_i  (ctr_adv),
        .bit_o  (bit_cur),
        .word_o (word_cur),
        .wrap_o (at_end)
    );

    // An origin is only "expected" on the adv that leaves word 107, bit 29.
    always_comb begin
        state_d    = state_q;
        miss_d     = miss_q;
        sync_err_d = sync_err_q;
        ctr_clr    = 1'b0;
        ctr_load   = 1'b0;
        ctr_adv    = 1'b0;
        case (state_q)
            g15_timing_pkg::HUNT: begin
                if (adv && ORIGIN) begin
                    ctr_load   = 1'b1;
                    state_d    = g15_timing_pkg::LOCKED;
                    sync_err_d = 1'b0;
                    miss_d     = '0;
                end else begin
                    ctr_clr = 1'b1;
                end
            end
            default: begin
                if (adv) begin
                    if (ORIGIN && !at_end) begin
                        ctr_load   = 1'b1;
                        sync_err_d = 1'b1;
                        miss_d     = '0;
                    end else begin
                        ctr_adv = 1'b1;
                        if (at_end) begin
                            if (ORIGIN) begin
                                miss_d = '0;
                            end else if (int'(miss_q) + 1 >= MISS_LIMIT) begin
                                state_d = g15_timing_pkg::HUNT;
                                ctr_clr = 1'b1;
                                miss_d  = '0;
                            end else begin
                                miss_d = miss_q + 1'b1;
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state_q    <= g15_timing_pkg::HUNT;
            miss_q     <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            miss_q     <= miss_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign locked    = (state_q == g15_timing_pkg::LOCKED);
    assign LOCKED    = locked;
    assign SYNC_ERR  = sync_err_q;
    assign BIT_TIME  = bit_cur;
    assign WORD_TIME = word_cur;

    // T0 is the word-boundary strobe and shares its decode with T29.
    assign T29 = locked && (bit_cur == LAST_BIT);
    assign T0  = T29;
    assign T1  = locked && (bit_cur == 5'd1);
    assign T2  = locked && (bit_cur == 5'd2);
    assign T13 = locked && (bit_cur == 5'd13);
    assign T21 = locked && (bit_cur == 5'd21);
    assign T28 = locked && (bit_cur == 5'd28);
    assign TE  = locked && !word_cur[0];
    assign TF  = locked && word_cur[0];
    assign TS  = locked && (word_cur == LAST_WORD);

endmodule

// File: tb/tb_drum_timing_gen.sv
// Scoreboard bench for drum_timing_gen: a behavioural drum model predicts every cycle.
module tb_drum_timing_gen;

    logic       CLOCK;
    logic       rst;
    logic       BIT_EN;
    logic       ORIGIN;
    logic       STEP_MODE;
    logic       STEP;
    logic [4:0] BIT_TIME;
    logic [6:0] WORD_TIME;
    logic       T0, T1, T2, T13, T21, T28, T29;
    logic       TE, TF, TS, LOCKED, SYNC_ERR;

    int errors = 0;
    int checks = 0;

    logic [23:0] expQ[$];
    logic [23:0] expv;

    bit mLocked;
    int mBit;
    int mWord;
    int mMiss;
    bit mSyncErr;

    drum_timing_gen dut (
        .CLOCK     (CLOCK),
        .rst       (rst),
        .BIT_EN    (BIT_EN),
        .ORIGIN    (ORIGIN),
        .STEP_MODE (STEP_MODE),
        .STEP      (STEP),
        .BIT_TIME  (BIT_TIME),
        .WORD_TIME (WORD_TIME),
        .T0        (T0),
        .T1        (T1),
        .T2        (T2),
        .T13       (T13),
        .T21       (T21),
        .T28       (T28),
        .T29       (T29),
        .TE        (TE),
        .TF        (TF),
        .TS        (TS),
        .LOCKED    (LOCKED),
        .SYNC_ERR  (SYNC_ERR)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    function automatic logic [23:0] getObs();
        return {BIT_TIME, WORD_TIME, T0, T1, T2, T13, T21, T28, T29, TE, TF, TS, LOCKED, SYNC_ERR};
    endfunction

    function automatic logic [23:0] expVec();
        logic [4:0] b;
        logic [6:0] w;
        logic       l;
        b = 5'(mBit);
        w = 7'(mWord);
        l = mLocked;
        return {b, w, l && (b == 5'd29), l && (b == 5'd1), l && (b == 5'd2), l && (b == 5'd13),
                l && (b == 5'd21), l && (b == 5'd28), l && (b == 5'd29), l && !w[0], l && w[0],
                l && (w == 7'd107), l, mSyncErr};
    endfunction

    // Reference drum behaviour for one advance.
    task automatic modelStep(input logic org);
        bit atEnd;
        if (!mLocked) begin
            if (org) begin
                mLocked  = 1;
                mBit     = 1;
                mWord    = 0;
                mMiss    = 0;
                mSyncErr = 0;
            end
        end else begin
            atEnd = (mBit == 29) && (mWord == 107);
            if (org && !atEnd) begin
                mSyncErr = 1;
                mBit     = 1;
                mWord    = 0;
                mMiss    = 0;
            end else begin
                if (mBit == 29) begin
                    mBit  = 1;
                    mWord = (mWord == 107) ? 0 : mWord + 1;
                end else begin
                    mBit = mBit + 1;
                end
                if (atEnd) begin
                    if (org) begin
                        mMiss = 0;
                    end else begin
                        mMiss = mMiss + 1;
                        if (mMiss >= 2) begin
                            mLocked = 0;
                            mBit    = 0;
                            mWord   = 0;
                            mMiss   = 0;
                        end
                    end
                end
            end
        end
    endtask

    // Drive one clock of inputs, predict the result and queue it.
    task automatic applyStimulus(input logic en, input logic org, input logic sm,
                                 input logic stp, input logic rs);
        logic advM;
        BIT_EN    = en;
        ORIGIN    = org;
        STEP_MODE = sm;
        STEP      = stp;
        rst       = rs;
`ifdef DRUM_TIMING_STEP_EN
        advM = sm ? stp : en;
`else
        advM = en;
`endif
        if (rs) begin
            mLocked  = 0;
            mBit     = 0;
            mWord    = 0;
            mMiss    = 0;
            mSyncErr = 0;
        end else if (advM) begin
            modelStep(org);
        end
        expQ.push_back(expVec());
        @(posedge CLOCK);
        #1;
        BIT_EN = 1'b0;
        ORIGIN = 1'b0;
        STEP   = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i == 3, i == 3, 1'b0, 1'b0, 1'b1);
            expv = expQ.pop_front();
            checks++;
            if (getObs() !== expv) begin
                errors++;
                $display("[TB] FAIL reset cycle %0d: got %h expected %h", i, getObs(), expv);
            end
        end
        checks++;
        if (getObs() !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_all_zero: got %h expected 000000", getObs());
        end
    endtask

    task automatic test_lock();
        for (int i = 1; i <= 10; i++) begin
            for (int g = 0; g < 4; g++) begin
                applyStimulus(g == 0, (g == 0) && (i == 10), 1'b0, 1'b0, 1'b0);
                expv = expQ.pop_front();
                checks++;
                if (getObs() !== expv) begin
                    errors++;
                    $display("[TB] FAIL lock adv %0d gap %0d: got %h expected %h", i, g, getObs(), expv);
                end
            end
        end
        checks++;
        if (!(BIT_TIME === 5'd1 && WORD_TIME === 7'd0 && LOCKED === 1'b1 && T1 === 1'b1 && TE === 1'b1)) begin
            errors++;
            $display("[TB] FAIL lock_state: got bit=%0d word=%0d locked=%b t1=%b te=%b expected 1 0 1 1 1",
                     BIT_TIME, WORD_TIME, LOCKED, T1, TE);
        end
    endtask

    task automatic test_full_rev();
        int  t29Count = 0;
        int  tsCount  = 0;
        logic org;
        for (int i = 0; i < 3132; i++) begin
            org = (mBit == 29) && (mWord == 107);
            applyStimulus(1'b1, org, 1'b0, 1'b0, 1'b0);
            expv = expQ.pop_front();
            checks++;
            if (getObs() !== expv) begin
                errors++;
                $display("[TB] FAIL full_rev adv %0d: got %h expected %h", i, getObs(), expv);
            end
            if (T29 === 1'b1) t29Count++;
            if (TS === 1'b1) tsCount++;
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            expv = expQ.pop_front();
            checks++;
            if (getObs() !== expv) begin
                errors++;
                $display("[TB] FAIL full_rev idle %0d: got %h expected %h", i, getObs(), expv);
            end
        end
        checks++;
        if (t29Count != 108 || tsCount != 29) begin
            errors++;
            $display("[TB] FAIL full_rev_counts: got t29=%0d ts=%0d expected 108 29", t29Count, tsCount);
        end
        checks++;
        if (!(SYNC_ERR === 1'b0 && BIT_TIME === 5'd1 && WORD_TIME === 7'd0 && LOCKED === 1'b1)) begin
            errors++;
            $display("[TB] FAIL full_rev_end: got err=%b bit=%0d word=%0d locked=%b expected 0 1 0 1",
                     SYNC_ERR, BIT_TIME, WORD_TIME, LOCKED);
        end
    endtask

    task automatic test_misalign();
        for (int i = 0; i <= 1172; i++) begin
            applyStimulus(1'b1, i == 1172, 1'b0, 1'b0, 1'b0);
            expv = expQ.pop_front();
            checks++;
            if (getObs() !== expv) begin
                errors++;
                $display("[TB] FAIL misalign adv %0d: got %h expected %h", i, getObs(), expv);
            end
            if (i == 1171) begin
                checks++;
                if (!(WORD_TIME === 7'd40 && BIT_TIME === 5'd13)) begin
                    errors++;
                    $display("[TB] FAIL misalign_pos: got word=%0d bit=%0d expected 40 13", WORD_TIME, BIT_TIME);
                end
            end
        end
        checks++;
        if (!(SYNC_ERR === 1'b1 && LOCKED === 1'b1 && BIT_TIME === 5'd1 && WORD_TIME === 7'd0)) begin
            errors++;
            $display("[TB] FAIL misalign_reload: got err=%b locked=%b bit=%0d word=%0d expected 1 1 1 0",
                     SYNC_ERR, LOCKED, BIT_TIME, WORD_TIME);
        end
    endtask

    task automatic test_lost_sync();
        for (int i = 0; i < 6264; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            expv = expQ.pop_front();
            checks++;
            if (getObs() !== expv) begin
                errors++;
                $display("[TB] FAIL lost_sync adv %0d: got %h expected %h", i, getObs(), expv);
            end
            if (i == 3131) begin
                checks++;
                if (LOCKED !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL lost_sync_first_miss: got locked=%b expected 1", LOCKED);
                end
            end
        end
        checks++;
        if (getObs() !== 24'h000001) begin
            errors++;
            $display("[TB] FAIL lost_sync_hunt: got %h expected 000001", getObs());
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i != 1, i == 3, 1'b0, 1'b0, 1'b0);
            expv = expQ.pop_front();
            checks++;
            if (getObs() !== expv) begin
                errors++;
                $display("[TB] FAIL relock cycle %0d: got %h expected %h", i, getObs(), expv);
            end
        end
        checks++;
        if (!(LOCKED === 1'b1 && SYNC_ERR === 1'b0 && BIT_TIME === 5'd1)) begin
            errors++;
            $display("[TB] FAIL relock_state: got locked=%b err=%b bit=%0d expected 1 0 1", LOCKED, SYNC_ERR, BIT_TIME);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 1615; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            expv = expQ.pop_front();
            checks++;
            if (getObs() !== expv) begin
                errors++;
                $display("[TB] FAIL mid_reset adv %0d: got %h expected %h", i, getObs(), expv);
            end
        end
        checks++;
        if (!(WORD_TIME === 7'd55 && BIT_TIME === 5'd21 && T21 === 1'b1)) begin
            errors++;
            $display("[TB] FAIL mid_reset_pos: got word=%0d bit=%0d t21=%b expected 55 21 1", WORD_TIME, BIT_TIME, T21);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        expv = expQ.pop_front();
        checks++;
        if (getObs() !== 24'h0 || getObs() !== expv) begin
            errors++;
            $display("[TB] FAIL mid_reset_clear: got %h expected 000000", getObs());
        end
    endtask

    task automatic test_step();
        int expBit;
        logic stp;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expv = expQ.pop_front();
        checks++;
        if (getObs() !== expv) begin
            errors++;
            $display("[TB] FAIL step_lock: got %h expected %h", getObs(), expv);
        end
        for (int i = 0; i < 8; i++) begin
            stp = (i == 1) || (i == 3) || (i == 6);
            applyStimulus(i[0], 1'b0, 1'b1, stp, 1'b0);
            expv = expQ.pop_front();
            checks++;
            if (getObs() !== expv) begin
                errors++;
                $display("[TB] FAIL step_mode cycle %0d: got %h expected %h", i, getObs(), expv);
            end
        end
`ifdef DRUM_TIMING_STEP_EN
        expBit = 4;
`else
        expBit = 5;
`endif
        checks++;
        if (BIT_TIME !== 5'(expBit)) begin
            errors++;
            $display("[TB] FAIL step_count: got bit=%0d expected %0d", BIT_TIME, expBit);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            expv = expQ.pop_front();
            checks++;
            if (getObs() !== expv) begin
                errors++;
                $display("[TB] FAIL step_ignored cycle %0d: got %h expected %h", i, getObs(), expv);
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        BIT_EN    = 1'b0;
        ORIGIN    = 1'b0;
        STEP_MODE = 1'b0;
        STEP      = 1'b0;
        mLocked   = 0;
        mBit      = 0;
        mWord     = 0;
        mMiss     = 0;
        mSyncErr  = 0;
        test_reset();
        test_lock();
        test_full_rev();
        test_misalign();
        test_lost_sync();
        test_mid_reset();
        test_step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
